// File: rtl/hps_reset_requester.sv
// Issues timed active-low cold/warm/debug reset requests toward the HPS, tracks the
// h2f_reset_n acknowledgement and reports each outcome on the STM hardware-event bus.
module hps_reset_requester #(
    parameter int unsigned PULSE_CYCLES   = 16,
    parameter int unsigned ACK_TIMEOUT    = 50000000,
    parameter int unsigned HOLDOFF_CYCLES = 1024,
    parameter int unsigned CNT_W          = 32
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        req_cold,
    input  logic        req_warm,
    input  logic        req_debug,
    input  logic [23:0] user_events,
    input  logic        h2f_reset_n,
    input  logic        clr_timeout,
    output logic        f2h_cold_reset_req_n,
    output logic        f2h_warm_reset_req_n,
    output logic        f2h_debug_reset_req_n,
    output logic [27:0] stm_hwevents,
    output logic        busy,
    output logic        timeout_flag
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ASSERT,
        S_WAIT_LO,
        S_WAIT_HI,
        S_HOLDOFF
    } state_t;

    typedef enum logic [1:0] {
        SEL_COLD,
        SEL_WARM,
        SEL_DEBUG
    } sel_t;

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'((HOLDOFF_CYCLES == 0) ? 0 : HOLDOFF_CYCLES - 1);

    state_t           r_state;
    sel_t             r_sel;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_pend;
    logic [2:0]       r_req_prev;
    logic [2:0]       r_req_n;
    logic [3:0]       r_evt;
    logic [23:0]      r_user_evt;
    logic             r_busy;
    logic             r_tflag;
    logic             r_h2f_meta;
    logic             r_h2f_s;

    logic [2:0]       w_req_now;
    logic [2:0]       w_rise;
    logic [2:0]       w_grant;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_ack_wait;
    logic             w_timeout;

    assign w_req_now = {req_debug, req_warm, req_cold};
    assign w_rise    = w_req_now & ~r_req_prev;

    // Fixed priority: bit0 cold, bit1 warm, bit2 debug.
    assign w_grant = r_pend[0] ? 3'b001 :
                     r_pend[1] ? 3'b010 :
                     r_pend[2] ? 3'b100 : 3'b000;

    assign w_cnt_inc  = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;
    assign w_ack_wait = ((r_state == S_WAIT_LO) && r_h2f_s) ||
                        ((r_state == S_WAIT_HI) && !r_h2f_s);
    assign w_timeout  = w_ack_wait && (r_cnt == ACK_LAST);

    // h2f_reset_n is asynchronous; only the synchronized copy is ever used.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_h2f_meta <= 1'b1;
            r_h2f_s    <= 1'b1;
            r_req_prev <= 3'b000;
            r_user_evt <= 24'd0;
        end else begin
            r_h2f_meta <= h2f_reset_n;
            r_h2f_s    <= r_h2f_meta;
            r_req_prev <= w_req_now;
            r_user_evt <= user_events;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state <= S_IDLE;
            r_sel   <= SEL_COLD;
            r_cnt   <= '0;
            r_pend  <= 3'b000;
            r_req_n <= 3'b111;
            r_evt   <= 4'b0000;
            r_busy  <= 1'b0;
            r_tflag <= 1'b0;
        end else begin
            r_evt  <= 4'b0000;
            r_pend <= r_pend | w_rise;

            case (r_state)
                S_IDLE: begin
                    if (|r_pend) begin
                        r_pend  <= (r_pend & ~w_grant) | w_rise;
                        r_req_n <= ~w_grant;
                        r_sel   <= r_pend[0] ? SEL_COLD : (r_pend[1] ? SEL_WARM : SEL_DEBUG);
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_ASSERT;
                    end
                end

                S_ASSERT: begin
                    if (r_cnt == PULSE_LAST) begin
                        r_req_n <= 3'b111;
                        r_cnt   <= '0;
                        if (r_sel == SEL_DEBUG) begin
                            r_evt[2] <= 1'b1;
                            r_state  <= S_HOLDOFF;
                        end else begin
                            r_state  <= S_WAIT_LO;
                        end
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end

                S_WAIT_LO: begin
                    if (!r_h2f_s) begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT_HI;
                    end else if (w_timeout) begin
                        r_evt[3] <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= S_HOLDOFF;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end

                S_WAIT_HI: begin
                    if (r_h2f_s) begin
                        if (r_sel == SEL_WARM) begin
                            r_evt[1] <= 1'b1;
                        end else begin
                            r_evt[0] <= 1'b1;
                        end
                        r_cnt   <= '0;
                        r_state <= S_HOLDOFF;
                    end else if (w_timeout) begin
                        r_evt[3] <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= S_HOLDOFF;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end

                S_HOLDOFF: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end

                default: begin
                    r_req_n <= 3'b111;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase

            // A new timeout wins over a coincident clear.
            if (w_timeout) begin
                r_tflag <= 1'b1;
            end else if (clr_timeout) begin
                r_tflag <= 1'b0;
            end
        end
    end

    assign f2h_cold_reset_req_n  = r_req_n[0];
    assign f2h_warm_reset_req_n  = r_req_n[1];
    assign f2h_debug_reset_req_n = r_req_n[2];
    assign stm_hwevents          = {r_user_evt, r_evt};
    assign busy                  = r_busy;
    assign timeout_flag          = r_tflag;

endmodule

// File: tb/tb_hps_reset_requester.sv
// Bench for hps_reset_requester: countdown-based reference model compared every cycle,
// directed scenarios with hand-computed timing, then randomized requests and HPS behaviour.
module tb_hps_reset_requester;

    localparam int PULSE = 16;
    localparam int ACK   = 100;
    localparam int HOLD  = 20;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic        req_cold = 1'b0, req_warm = 1'b0, req_debug = 1'b0;
    logic [23:0] user_events = 24'd0;
    logic        h2f_reset_n;
    logic        clr_timeout = 1'b0;
    logic        f2h_cold_reset_req_n, f2h_warm_reset_req_n, f2h_debug_reset_req_n;
    logic [27:0] stm_hwevents;
    logic        busy, timeout_flag;

    logic h2f_manual = 1'b1;
    logic h2f_auto   = 1'b1;
    assign h2f_reset_n = h2f_manual & h2f_auto;

    hps_reset_requester #(
        .PULSE_CYCLES  (PULSE),
        .ACK_TIMEOUT   (ACK),
        .HOLDOFF_CYCLES(HOLD),
        .CNT_W         (16)
    ) dut (
        .clk_clk              (clk_clk),
        .reset_reset_n        (reset_reset_n),
        .req_cold             (req_cold),
        .req_warm             (req_warm),
        .req_debug            (req_debug),
        .user_events          (user_events),
        .h2f_reset_n          (h2f_reset_n),
        .clr_timeout          (clr_timeout),
        .f2h_cold_reset_req_n (f2h_cold_reset_req_n),
        .f2h_warm_reset_req_n (f2h_warm_reset_req_n),
        .f2h_debug_reset_req_n(f2h_debug_reset_req_n),
        .stm_hwevents         (stm_hwevents),
        .busy                 (busy),
        .timeout_flag         (timeout_flag)
    );

    always #5 clk_clk = ~clk_clk;

    // Reference model: phase 0 idle, 1 pulse, 2 await ack low, 3 await ack high, 4 holdoff.
    int       m_phase = 0;
    int       m_left  = 0;
    int       m_who   = 0;
    bit [2:0] m_pend = 0, m_prev = 0, m_req = 0, m_rise = 0;
    bit       m_s1 = 1, m_s2 = 1, m_ack = 1, m_to = 0, m_flag = 0;
    bit [2:0] m_low_n = 3'b111;
    bit [3:0] m_evt = 0;
    bit [23:0] m_user = 0;

    always @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            m_phase = 0; m_left = 0; m_who = 0; m_pend = 0; m_prev = 0;
            m_s1 = 1; m_s2 = 1; m_flag = 0; m_low_n = 3'b111; m_evt = 0; m_user = 0;
        end else begin
            m_req  = {req_debug, req_warm, req_cold};
            m_rise = m_req & ~m_prev;
            m_prev = m_req;
            m_ack  = m_s2;
            m_evt  = 0;
            m_to   = 0;
            case (m_phase)
                0: if (m_pend != 0) begin
                    m_who = m_pend[0] ? 0 : (m_pend[1] ? 1 : 2);
                    m_pend[m_who] = 1'b0;
                    m_low_n = 3'b111;
                    m_low_n[m_who] = 1'b0;
                    m_phase = 1; m_left = PULSE;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_low_n = 3'b111;
                        if (m_who == 2) begin m_evt[2] = 1; m_phase = 4; m_left = HOLD; end
                        else begin m_phase = 2; m_left = ACK; end
                    end
                end
                2: if (!m_ack) begin m_phase = 3; m_left = ACK; end
                   else begin m_left--; if (m_left == 0) m_to = 1; end
                3: if (m_ack) begin m_evt[m_who] = 1; m_phase = 4; m_left = HOLD; end
                   else begin m_left--; if (m_left == 0) m_to = 1; end
                default: begin m_left--; if (m_left == 0) m_phase = 0; end
            endcase
            if (m_to) begin m_evt[3] = 1; m_phase = 4; m_left = HOLD; m_flag = 1; end
            else if (clr_timeout) m_flag = 0;
            m_pend = m_pend | m_rise;
            m_s2 = m_s1;
            m_s1 = h2f_reset_n;
            m_user = user_events;
        end
    end

    // HPS stand-in: answers cold/warm requests with a delayed low pulse, sometimes not at all.
    bit auto_en = 0, resp_always = 0, noise_en = 0;
    int rs = 0, rcnt = 0;
    always @(posedge clk_clk) begin
        #1;
        if (!auto_en) begin
            h2f_auto = 1'b1; rs = 0;
        end else begin
            case (rs)
                0: begin
                    h2f_auto = 1'b1;
                    if (!f2h_cold_reset_req_n || !f2h_warm_reset_req_n) begin
                        if (resp_always || $urandom_range(0, 7) != 0) begin
                            rs = 1; rcnt = $urandom_range(1, 12);
                        end else rs = 3;
                    end else if (noise_en && $urandom_range(0, 299) == 0) begin
                        rs = 2; rcnt = $urandom_range(1, 4);
                    end
                end
                1: begin
                    rcnt--;
                    if (rcnt == 0) begin rs = 2; rcnt = resp_always ? 40 : $urandom_range(1, 40); end
                end
                2: begin h2f_auto = 1'b0; rcnt--; if (rcnt == 0) rs = 3; end
                3: begin h2f_auto = 1'b1; if (f2h_cold_reset_req_n && f2h_warm_reset_req_n) rs = 0; end
                default: rs = 0;
            endcase
        end
    end

    int total = 0, bad = 0, cyc = 0;
    int n_cold_low, n_warm_low, n_dbg_low, n_e0, n_e1, n_e2, n_e3;
    int cold_first, cold_last, warm_last, dbg_first, dbg_last;
    int e0_cyc, e2_cyc, flag_cyc, idle_cyc;
    int n_overlap = 0;
    bit drop_clr_on_flag = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clr_track();
        n_cold_low = 0; n_warm_low = 0; n_dbg_low = 0;
        n_e0 = 0; n_e1 = 0; n_e2 = 0; n_e3 = 0;
        cold_first = -1; cold_last = -1; warm_last = -1; dbg_first = -1; dbg_last = -1;
        e0_cyc = -1; e2_cyc = -1; flag_cyc = -1; idle_cyc = -1;
    endtask

    task automatic sample();
        logic [2:0] lows;
        @(negedge clk_clk);
        cyc++;
        lows = {f2h_debug_reset_req_n, f2h_warm_reset_req_n, f2h_cold_reset_req_n};
        check("req_n", 32'(lows), 32'(m_low_n));
        check("stm_hwevents", 32'(stm_hwevents), 32'({m_user, m_evt}));
        check("busy", 32'(busy), 32'(m_phase != 0));
        check("timeout_flag", 32'(timeout_flag), 32'(m_flag));
        if (!lows[0]) begin n_cold_low++; if (cold_first < 0) cold_first = cyc; cold_last = cyc; end
        if (!lows[1]) begin n_warm_low++; warm_last = cyc; end
        if (!lows[2]) begin n_dbg_low++; if (dbg_first < 0) dbg_first = cyc; dbg_last = cyc; end
        if ($countones(~lows) > 1) n_overlap++;
        if (stm_hwevents[0]) begin n_e0++; if (e0_cyc < 0) e0_cyc = cyc; end
        if (stm_hwevents[1]) n_e1++;
        if (stm_hwevents[2]) begin n_e2++; if (e2_cyc < 0) e2_cyc = cyc; end
        if (stm_hwevents[3]) n_e3++;
        if (timeout_flag && flag_cyc < 0) flag_cyc = cyc;
        if (!busy && e0_cyc >= 0 && idle_cyc < 0) idle_cyc = cyc;
        if (drop_clr_on_flag && timeout_flag) clr_timeout = 1'b0;
    endtask

    task automatic adv();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic cycle();
        sample();
        adv();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    int c_rise;

    initial begin
        clr_track();
        // Reset state
        adv(); adv();
        sample();
        check("rst_req_n", 32'({f2h_debug_reset_req_n, f2h_warm_reset_req_n, f2h_cold_reset_req_n}), 32'h7);
        check("rst_stm", 32'(stm_hwevents), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_tflag", 32'(timeout_flag), 32'h0);
        adv();
        reset_reset_n = 1'b1;
        run(3);

        // Cold path with a manual HPS acknowledgement
        clr_track();
        req_cold = 1'b1; cycle(); req_cold = 1'b0;
        run(4);
        h2f_manual = 1'b0;
        run(100);
        h2f_manual = 1'b1;
        c_rise = cyc;
        run(40);
        check("cold_low_cycles", n_cold_low, PULSE);
        check("cold_evt_count", n_e0, 1);
        check("cold_ack_latency", e0_cyc - c_rise - 1, 3);
        check("cold_holdoff", idle_cyc - e0_cyc, HOLD);
        check("cold_no_timeout", n_e3, 0);

        // Debug path: no ack expected
        clr_track();
        req_debug = 1'b1; cycle(); req_debug = 1'b0;
        run(60);
        check("dbg_low_cycles", n_dbg_low, PULSE);
        check("dbg_evt_count", n_e2, 1);
        check("dbg_evt_timing", e2_cyc, dbg_last + 1);
        check("dbg_tflag", 32'(timeout_flag), 32'h0);

        // Warm request never acknowledged
        clr_track();
        req_warm = 1'b1; cycle(); req_warm = 1'b0;
        run(130);
        check("warm_low_cycles", n_warm_low, PULSE);
        check("timeout_latency", flag_cyc - (warm_last + 1), ACK);
        check("timeout_evt_count", n_e3, 1);
        check("warm_no_success", n_e1, 0);
        clr_timeout = 1'b1; cycle(); clr_timeout = 1'b0;
        sample();
        check("tflag_cleared", 32'(timeout_flag), 32'h0);
        adv();

        // Clear held through a fresh timeout: set must win
        clr_track();
        clr_timeout = 1'b1; drop_clr_on_flag = 1'b1;
        req_warm = 1'b1; cycle(); req_warm = 1'b0;
        for (int i = 0; i < 300; i++) begin
            cycle();
            if (flag_cyc >= 0) break;
        end
        drop_clr_on_flag = 1'b0; clr_timeout = 1'b0;
        check("tflag_seen_within_bound", 32'(flag_cyc >= 0), 32'h1);
        run(3);
        check("tflag_set_wins", 32'(timeout_flag), 32'h1);
        run(30);

        // Priority: debug and cold rise together
        clr_track();
        auto_en = 1'b1; resp_always = 1'b1; noise_en = 1'b0;
        req_debug = 1'b1; req_cold = 1'b1; cycle();
        req_debug = 1'b0; req_cold = 1'b0;
        run(200);
        check("prio_cold_evt", n_e0, 1);
        check("prio_dbg_evt", n_e2, 1);
        check("prio_order", 32'(cold_first >= 0 && dbg_first > cold_last), 32'h1);
        check("prio_dbg_after_holdoff", dbg_first - e0_cyc, HOLD + 1);
        auto_en = 1'b0;
        run(5);

        // Async reset in the middle of a cold pulse
        clr_track();
        req_cold = 1'b1; cycle(); req_cold = 1'b0;
        for (int i = 0; i < 40; i++) begin
            sample();
            if (n_cold_low == 8) break;
            adv();
        end
        #2 reset_reset_n = 1'b0;
        #1;
        check("async_rst_cold_high", 32'(f2h_cold_reset_req_n), 32'h1);
        check("async_rst_busy", 32'(busy), 32'h0);
        adv();
        run(2);
        reset_reset_n = 1'b1;
        clr_track();
        run(60);
        check("no_reissue", n_cold_low, 0);
        check("post_rst_idle", 32'(busy), 32'h0);

        // User event pass-through
        user_events = 24'hA5A5A5;
        sample();
        check("user_evt_before", 32'(stm_hwevents[27:4]), 32'h0);
        adv();
        sample();
        check("user_evt_after", 32'(stm_hwevents[27:4]), 32'hA5A5A5);
        check("user_evt_low_bits", 32'(stm_hwevents[3:0]), 32'h0);
        adv();

        // Randomized requests, clears, user events and HPS behaviour
        auto_en = 1'b1; resp_always = 1'b0; noise_en = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 31) == 0) req_cold  = ~req_cold;
            if ($urandom_range(0, 31) == 0) req_warm  = ~req_warm;
            if ($urandom_range(0, 31) == 0) req_debug = ~req_debug;
            clr_timeout = ($urandom_range(0, 39) == 0);
            user_events = 24'($urandom());
            cycle();
        end
        req_cold = 1'b0; req_warm = 1'b0; req_debug = 1'b0; clr_timeout = 1'b0;
        run(20);
        check("never_overlapping", n_overlap, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
